mips_bus_arb4: RTL and testbench
================================

# mips_bus_arb4

Round-robin arbiter that shares one slave port (memory/peripheral bus) between four masters and drives the 2-bit select of the 4:1 datapath mux that steers master address/data onto that port. It holds a grant for a whole transaction, ends it on the slave's done strobe or when the master withdraws, and inserts one turnaround cycle between owners. It sits between the core/DMA/debug request lines and the shared-bus mux select in the SoC interconnect.

## Interface
- `TIMEOUT`, default 255: maximum cycles a grant is held without `slv_done`. Used only with `ARB_TIMEOUT_EN`. Legal range is 1..255.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  4  level request per master. `req[i]` stays high until master i's transaction ends.
- `slv_done`  in  1  one-cycle strobe from the shared slave: the current transaction has completed.
- `gnt`  out  4  one-hot grant, registered. It is all-zero when no master owns the bus.
- `sel`  out  2  index of the current or last owner. It drives the shared 4:1 mux select.
- `busy`  out  1  high while any `gnt` bit is high.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout. It is tied 0 when the macro is absent.

## Operation
- The FSM has three states: IDLE, GRANT and RELEASE. It is encoded in 2 bits, and the unused code goes to IDLE.
- Reset values: state=IDLE, `gnt`=0, `sel`=0, `busy`=0, `timeout_err`=0, round-robin pointer `ptr`=3. With `ptr`=3, master 0 has top priority after reset.
- Arbitration is evaluated in IDLE and RELEASE.
  - The winner is the first `req[i]` set, searching from index (`ptr`+1) mod 4 upward with wrap-around.
  - On a win: go to GRANT, set `gnt`=one-hot(i), `sel`=i, `ptr`=i.
- GRANT to RELEASE happens on `slv_done`=1, or on `req[sel]`=0 (master abort), or on timeout.
  - Simultaneous `slv_done` and `req` drop count as a single release.
  - On entering RELEASE, `gnt` goes to 0.
- RELEASE lasts exactly one cycle with `gnt`=0 (bus turnaround).
  - If any `req` is pending, the next state is GRANT to the new winner.
  - Otherwise the next state is IDLE.
- `sel` holds its last value in IDLE and RELEASE. It changes only when a new grant is issued.
- Priority: after master i is served, i has the lowest priority in the next arbitration. No master waits more than 3 foreign grants.
- `slv_done` in IDLE or RELEASE is ignored.
- `req` changes by non-owners during GRANT do not affect the grant.
- Reset asserted mid-GRANT: at the next edge all outputs and `ptr` take their reset values. No RELEASE cycle and no error pulse are produced.

## Timing
- Request to grant: `req[i]` rises while in IDLE before edge N, and `gnt[i]`/`sel` are valid after edge N. Latency is 1 cycle.
- Release: `slv_done` is sampled high at edge K. Then `gnt`=0 after K (RELEASE), and the next owner's `gnt` is set after K+1.
- Back-to-back ownership change costs exactly 1 dead cycle.
- `busy` equals the OR of `gnt` and is registered with it (no extra latency).
- All outputs are registered. There are no combinational paths from `req`/`slv_done` to outputs.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit cycle counter clears on each new grant and increments every cycle in GRANT.
  - When the counter equals `TIMEOUT` with `slv_done`=0, the FSM is forced to RELEASE.
  - `timeout_err` is 1 during that RELEASE cycle only. `ptr` still advances, so the stuck master loses priority.
  - `slv_done` on the same cycle as the timeout edge wins, and no error pulse is produced.
- `ARB_TIMEOUT_EN` undefined:
  - The counter logic is absent and `timeout_err` is constant 0.
  - A grant lasts until `slv_done` or master abort, with no bound.

## Test plan
- Reset then `req`=4'b1111 held, with `slv_done` strobed 2 cycles after each grant. Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001 with `sel` 0,1,2,3,0, and exactly one `gnt`=0 cycle between grants.
- `req`=4'b0100 only, strobe `slv_done` on the 3rd GRANT cycle. Required: `gnt`=0100 and `sel`=2 one cycle after `req`; `gnt`=0 after the `slv_done` edge; `sel` stays 2; IDLE with `busy`=0 while `req` is low.
- Master 1 granted, drop `req[1]` without `slv_done` while `req[3]`=1. Required: one RELEASE cycle, then `gnt`=1000 and `sel`=3.
- Assert `rst` while master 2 is granted. Required: next cycle `gnt`=0, `sel`=0, `busy`=0, `timeout_err`=0. A following `req`=4'b1001 grants master 0 first.
- With `ARB_TIMEOUT_EN` and `TIMEOUT`=4, grant master 0 and never send `slv_done`. Required: `gnt` drops after 4 GRANT cycles and `timeout_err` pulses 1 for one cycle. A pending `req[1]` then gets `gnt`=0010. The same stimulus without the macro holds `gnt`=0001 indefinitely with `timeout_err`=0.
- Send `slv_done` during IDLE with `req`=0. Required: no state change and all outputs unchanged.

Source files
------------

// File: rtl/mips_bus_arb4_if.sv
// mips_bus_arb4_if: request/grant bundle between the four bus masters and the
// shared-slave arbiter.
//   req[3:0]     level request per master
//   slv_done     one-cycle completion strobe from the shared slave
//   gnt[3:0]     one-hot registered grant
//   sel[1:0]     current/last owner index, drives the 4:1 datapath mux
//   busy         OR of gnt
//   timeout_err  one-cycle pulse when a grant is revoked by timeout
interface mips_bus_arb4_if;
  logic [3:0] req;
  logic       slv_done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  // Requesters and slave side: drive req/slv_done, observe the grant.
  modport master (
    output req, slv_done,
    input  gnt, sel, busy, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req, slv_done,
    output gnt, sel, busy, timeout_err
  );
endinterface

// File: rtl/mips_bus_arb4.sv
// mips_bus_arb4: four-master round-robin arbiter for one shared slave port.
// Holds a grant for a whole transaction, releases on slv_done or master
// withdrawal, and inserts one turnaround cycle (gnt=0) between owners.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  mips_bus_arb4_if.slave (req, slv_done in; gnt, sel, busy,
//        timeout_err out, all outputs registered)
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant held TIMEOUT
// cycles without slv_done; otherwise timeout_err is constant 0.
module mips_bus_arb4 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_bus_arb4_if.slave       bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       terr_q, terr_d;
  logic [1:0] ptr_q, ptr_d;

  logic       win_vld_c;
  logic [1:0] win_idx_c;
  logic [1:0] cand_c;
  logic       tmo_c;
  logic       cnt_clr_c;

  // Round-robin search starting just after the last owner.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = ptr_q;
    cand_c    = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand_c = ptr_q + 2'(k);
      if (!win_vld_c && bus.req[cand_c]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand_c;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;

  // Cycle count of the current grant; the cycle whose incremented count
  // reaches TIMEOUT is the last GRANT cycle.
  always_comb begin
    cnt_inc_c = cnt_q + CNT_W'(1);
    tmo_c     = (state_q == GRANT) && (cnt_inc_c == CNT_W'(TIMEOUT));
    cnt_d     = cnt_q;
    if (cnt_clr_c)              cnt_d = '0;
    else if (state_q == GRANT)  cnt_d = cnt_inc_c;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // A legal TIMEOUT is never 0, so no timeout is ever raised.
  assign tmo_c = (TIMEOUT == 0) && 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    terr_d    = 1'b0;
    cnt_clr_c = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (win_vld_c) begin
          state_d   = GRANT;
          gnt_d     = 4'b0001 << win_idx_c;
          sel_d     = win_idx_c;
          ptr_d     = win_idx_c;
          busy_d    = 1'b1;
          cnt_clr_c = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (bus.slv_done || !bus.req[sel_q] || tmo_c) begin
          state_d = RELEASE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          // slv_done on the timeout cycle counts as a normal completion
          terr_d  = tmo_c && !bus.slv_done;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mips_bus_arb4.sv
// tb_mips_bus_arb4: vector table plus hand-written timeout sequence for
// mips_bus_arb4; expected outputs go through a scoreboard queue.
module tb_mips_bus_arb4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       terr;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  mips_bus_arb4_if bus ();

  mips_bus_arb4 #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic [3:0] rq, input logic d,
                         input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d;
    v.exp = '{gnt: g, sel: s, busy: b, terr: t};
    vecs.push_back(v);
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic d, input exp_t e);
    exp_t want, got;
    rst          = r;
    bus.req      = rq;
    bus.slv_done = d;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = '{gnt: bus.gnt, sel: bus.sel, busy: bus.busy, terr: bus.timeout_err};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: gnt=%b sel=%0d busy=%b terr=%b, required gnt=%b sel=%0d busy=%b terr=%b",
               name, got.gnt, got.sel, got.busy, got.terr,
               want.gnt, want.sel, want.busy, want.terr);
    end
  endtask

  initial begin
    rst = 1'b1; bus.req = 4'b0000; bus.slv_done = 1'b0;

    //       rst req     done  gnt     sel  busy terr
    add_vec(1, 4'b0000, 0,   4'b0000, 0,   0,   0);   // reset state
    // all request, done on 2nd grant cycle, one dead cycle between owners
    add_vec(0, 4'b1111, 0,   4'b0001, 0,   1,   0);
    add_vec(0, 4'b1111, 0,   4'b0001, 0,   1,   0);
    add_vec(0, 4'b1111, 1,   4'b0000, 0,   0,   0);
    add_vec(0, 4'b1111, 0,   4'b0010, 1,   1,   0);
    add_vec(0, 4'b1111, 0,   4'b0010, 1,   1,   0);
    add_vec(0, 4'b1111, 1,   4'b0000, 1,   0,   0);
    add_vec(0, 4'b1111, 0,   4'b0100, 2,   1,   0);
    add_vec(0, 4'b1111, 0,   4'b0100, 2,   1,   0);
    add_vec(0, 4'b1111, 1,   4'b0000, 2,   0,   0);
    add_vec(0, 4'b1111, 0,   4'b1000, 3,   1,   0);
    add_vec(0, 4'b1111, 0,   4'b1000, 3,   1,   0);
    add_vec(0, 4'b1111, 1,   4'b0000, 3,   0,   0);
    add_vec(0, 4'b1111, 0,   4'b0001, 0,   1,   0);
    add_vec(0, 4'b1111, 1,   4'b0000, 0,   0,   0);
    add_vec(0, 4'b0000, 0,   4'b0000, 0,   0,   0);   // RELEASE -> IDLE
    // single master 2, done with req drop on 3rd grant cycle
    add_vec(0, 4'b0100, 0,   4'b0100, 2,   1,   0);
    add_vec(0, 4'b0100, 0,   4'b0100, 2,   1,   0);
    add_vec(0, 4'b0100, 0,   4'b0100, 2,   1,   0);
    add_vec(0, 4'b0000, 1,   4'b0000, 2,   0,   0);
    add_vec(0, 4'b0000, 0,   4'b0000, 2,   0,   0);
    add_vec(0, 4'b0000, 1,   4'b0000, 2,   0,   0);   // done in IDLE ignored
    add_vec(0, 4'b0000, 0,   4'b0000, 2,   0,   0);
    // master 1 aborts while master 3 waits
    add_vec(0, 4'b0010, 0,   4'b0010, 1,   1,   0);
    add_vec(0, 4'b1010, 0,   4'b0010, 1,   1,   0);   // non-owner req ignored
    add_vec(0, 4'b1000, 0,   4'b0000, 1,   0,   0);
    add_vec(0, 4'b1000, 0,   4'b1000, 3,   1,   0);
    add_vec(0, 4'b0000, 1,   4'b0000, 3,   0,   0);
    add_vec(0, 4'b0000, 0,   4'b0000, 3,   0,   0);
    // reset mid-grant, then master 0 first
    add_vec(0, 4'b0100, 0,   4'b0100, 2,   1,   0);
    add_vec(1, 4'b0100, 0,   4'b0000, 0,   0,   0);
    add_vec(0, 4'b1001, 0,   4'b0001, 0,   1,   0);
    add_vec(0, 4'b1001, 1,   4'b0000, 0,   0,   0);
    add_vec(0, 4'b1001, 0,   4'b1000, 3,   1,   0);
    add_vec(0, 4'b0000, 0,   4'b0000, 3,   0,   0);
    add_vec(0, 4'b0000, 0,   4'b0000, 3,   0,   0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].exp);

    // master 0 granted with master 1 pending, slv_done never arrives
    step("tmo_grant", 0, 4'b0011, 0, '{4'b0001, 2'd0, 1'b1, 1'b0});
`ifdef ARB_TIMEOUT_EN
    for (int i = 2; i <= 4; i++)
      step($sformatf("tmo_hold%0d", i), 0, 4'b0011, 0, '{4'b0001, 2'd0, 1'b1, 1'b0});
    step("tmo_release", 0, 4'b0011, 0, '{4'b0000, 2'd0, 1'b0, 1'b1});
    step("tmo_next",    0, 4'b0010, 0, '{4'b0010, 2'd1, 1'b1, 1'b0});
    // slv_done on the timeout cycle: ordinary release, no error pulse
    for (int i = 2; i <= 3; i++)
      step($sformatf("tmo2_hold%0d", i), 0, 4'b0010, 0, '{4'b0010, 2'd1, 1'b1, 1'b0});
    step("tmo2_done", 0, 4'b0010, 1, '{4'b0000, 2'd1, 1'b0, 1'b0});
    step("tmo2_idle", 0, 4'b0000, 0, '{4'b0000, 2'd1, 1'b0, 1'b0});
`else
    for (int i = 2; i <= 12; i++)
      step($sformatf("hold%0d", i), 0, 4'b0011, 0, '{4'b0001, 2'd0, 1'b1, 1'b0});
    step("hold_done", 0, 4'b0010, 1, '{4'b0000, 2'd0, 1'b0, 1'b0});
    step("hold_next", 0, 4'b0010, 0, '{4'b0010, 2'd1, 1'b1, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
